// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive FIFO: capture FSM encoding and
// default geometry.
package uart_rx_fifo_pkg;

   typedef enum logic {
      RXF_IDLE = 1'b0,
      RXF_ACK  = 1'b1
   } rxf_state_t;

   localparam int DEFAULT_DEPTH_LOG2 = 4;
   localparam int DEFAULT_WIDTH      = 8;

endpackage

// File: rtl/fifo_ram_sp.sv
// DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous read port; maps to LUT RAM or plain registers.
module fifo_ram_sp
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int WIDTH      = DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] waddr,
   input  logic [WIDTH-1:0]      wdata,
   input  logic [DEPTH_LOG2-1:0] raddr,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

   // NOTE: no reset on the array; validity is tracked by the pointers and
   // count, and a reset port would block LUT-RAM inference.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Drains bytes from the UART receiver (valid/rd handshake) into a show-ahead
// FIFO read by the CPU, with occupancy count and sticky overrun flag.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
   parameter int WIDTH      = DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  uart_valid,
   input  logic [WIDTH-1:0]      uart_data,
   output logic                  uart_rd,
   input  logic                  cpu_rd,
   output logic                  cpu_valid,
   output logic [WIDTH-1:0]      cpu_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overrun,
   input  logic                  clr_overrun
);

   localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

   rxf_state_t            state;
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [WIDTH-1:0]      head;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   logic                  held_off;

   // Flags come from the registered count only, so a same-cycle pop never
   // opens a slot for a same-cycle push.
   assign full     = (count == DEPTH_CNT);
   assign empty    = (count == '0);
   assign push     = (state == RXF_IDLE) && uart_valid && !full;
   assign held_off = (state == RXF_IDLE) && uart_valid && full;
   assign pop      = cpu_rd && !empty;

   fifo_ram_sp #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (push),
      .waddr (wptr),
      .wdata (uart_data),
      .raddr (rptr),
      .rdata (head)
   );

   // NOTE: all state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= RXF_IDLE;
         uart_rd <= 1'b0;
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         overrun <= 1'b0;
      end else begin
         case (state)
            RXF_IDLE: begin
               if (push) begin
                  wptr    <= wptr + 1'b1;
                  uart_rd <= 1'b1;
                  state   <= RXF_ACK;
               end
            end
            RXF_ACK: begin
               uart_rd <= 1'b0;
               state   <= RXF_IDLE;
            end
            default: state <= RXF_IDLE;
         endcase

         if (pop) rptr <= rptr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (held_off)         overrun <= 1'b1;
         else if (clr_overrun) overrun <= 1'b0;
      end
   end

   assign cpu_valid = !empty;
   assign cpu_data  = empty ? '0 : head;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus a random
// push/pop phase scored against a queue model of the FIFO.
module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       uart_valid;
   logic [7:0] uart_data;
   logic       uart_rd;
   logic       cpu_rd;
   logic       cpu_valid;
   logic [7:0] cpu_data;
   logic [4:0] count;
   logic       overrun;
   logic       clr_overrun;

   int n_total = 0;
   int n_pass  = 0;
   logic [7:0] q[$];

   uart_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .uart_valid  (uart_valid),
      .uart_data   (uart_data),
      .uart_rd     (uart_rd),
      .cpu_rd      (cpu_rd),
      .cpu_valid   (cpu_valid),
      .cpu_data    (cpu_data),
      .count       (count),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected outputs follow directly from the model queue contents.
   task automatic check_outputs(input string tag);
      check({tag, "_count"}, count, q.size());
      check({tag, "_valid"}, cpu_valid, (q.size() != 0));
      check({tag, "_data"}, cpu_data, (q.size() != 0) ? q[0] : 8'h00);
   endtask

   // Behaves like the UART: holds valid until the ack strobe is seen.
   task automatic send_byte(input logic [7:0] b);
      bit got = 0;
      uart_valid = 1'b1;
      uart_data  = b;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (uart_rd) got = 1;
      end
      uart_valid = 1'b0;
      check("ack_seen", got, 1);
      if (got) begin
         q.push_back(b);
         check_outputs("after_push");
         step();
         check("ack_width", uart_rd, 0);
      end
   endtask

   task automatic pop_byte();
      check_outputs("before_pop");
      cpu_rd = 1'b1;
      step();
      cpu_rd = 1'b0;
      if (q.size() != 0) void'(q.pop_front());
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] held;
      bit got;

      reset = 1'b1; uart_valid = 1'b0; uart_data = 8'h00;
      cpu_rd = 1'b0; clr_overrun = 1'b0;
      #2;
      check("rst_uart_rd", uart_rd, 0);
      check("rst_overrun", overrun, 0);
      check_outputs("rst");
      step(); step();
      reset = 1'b0;
      step();

      // Single byte round trip
      send_byte(8'h41);
      pop_byte();
      check_outputs("single_empty");

      // Fill, partial drain, refill across the pointer wrap, full drain
      for (int i = 0; i < 16; i++) send_byte(8'(i));
      check("fill_count", count, 16);
      for (int i = 0; i < 4; i++) pop_byte();
      for (int i = 16; i < 20; i++) send_byte(8'(i));
      check("wrap_head", cpu_data, 8'h04);
      while (q.size() != 0) pop_byte();
      check_outputs("wrap_empty");

      // Full hold-off: byte stays with the UART, overrun flags it
      for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
      uart_valid = 1'b1; uart_data = 8'h55;
      for (int i = 0; i < 3; i++) begin
         step();
         check("holdoff_no_ack", uart_rd, 0);
      end
      check("holdoff_overrun", overrun, 1);
      check("holdoff_count", count, 16);
      pop_byte();
      got = 0;
      for (int i = 0; i < 2 && !got; i++) begin
         step();
         if (uart_rd) got = 1;
      end
      uart_valid = 1'b0;
      check("holdoff_capture", got, 1);
      if (got) q.push_back(8'h55);
      step();
      check("holdoff_refill", count, 16);

      // Clear alone, then clear colliding with a new hold-off
      clr_overrun = 1'b1;
      step();
      clr_overrun = 1'b0;
      check("clr_alone", overrun, 0);
      uart_valid = 1'b1; uart_data = 8'h66; clr_overrun = 1'b1;
      step();
      uart_valid = 1'b0; clr_overrun = 1'b0;
      check("set_beats_clr", overrun, 1);
      check("set_beats_clr_no_ack", uart_rd, 0);

      // Drain, tail must be the held-off byte, then pop on empty is ignored
      while (q.size() > 1) pop_byte();
      check("tail_is_0x55", cpu_data, 8'h55);
      pop_byte();
      cpu_rd = 1'b1;
      step();
      cpu_rd = 1'b0;
      check_outputs("pop_on_empty");

      // Simultaneous push and pop at occupancy 5
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      r = 8'($urandom);
      uart_valid = 1'b1; uart_data = r; cpu_rd = 1'b1;
      step();
      uart_valid = 1'b0; cpu_rd = 1'b0;
      void'(q.pop_front());
      q.push_back(r);
      check("simul_ack", uart_rd, 1);
      check_outputs("simul");
      step();

      // Random traffic against the queue model
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(1, 0) == 1 && q.size() < 16) send_byte(8'($urandom));
         else if (q.size() != 0) pop_byte();
         else step();
      end
      check_outputs("random_end");
      while (q.size() != 0) pop_byte();
      check_outputs("random_drained");

      // Asynchronous reset landing in the ack cycle
      send_byte(8'h11);
      held = 8'h22;
      uart_valid = 1'b1; uart_data = held;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         step();
         if (uart_rd) got = 1;
      end
      check("pre_reset_ack", got, 1);
      #2 reset = 1'b1;
      #1;
      q.delete();
      check("async_rst_uart_rd", uart_rd, 0);
      check_outputs("async_rst");
      uart_valid = 1'b0;
      step();
      reset = 1'b0;
      step();
      check_outputs("post_reset");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
